jt6295_adpcm_mix: RTL and testbench
===================================

# jt6295_adpcm_mix

Receiving end of the JT6295 serialized nibble stream. Each `cen` slot carries one channel's ADPCM nibble and attenuation in a fixed 4-channel rotation. The block decodes each nibble with the OKI/Dialogic ADPCM algorithm, keeping independent per-channel predictor state. It then applies the channel attenuation and sums the four channels into one signed PCM sample per frame for the sound output.

## Interface
Parameters:
- none

Ports:
- `rst`  in  1  reset, asynchronous, active-high
- `clk`  in  1  clock
- `cen`  in  1  slot enable; one channel slot per pulse
- `pipe_en`  in  1  the channel in this slot is active
- `pipe_att`  in  4  attenuation code for this slot
- `pipe_data`  in  4  ADPCM nibble; bit 3 is the sign, bits 2:0 the magnitude
- `sound`  out  14  signed mixed sample; reset value 0
- `sample`  out  1  one-`clk` strobe when `sound` updates; reset value 0

## Operation
- **Slot counter:** 2 bits, reset 0, increments on each `cen` and wraps 3→0. Slot 0 is the first `cen` after reset. A frame is slots 0..3.
- **Channel state:** 12-bit signed `signal` and 6-bit `index` (0..48) per channel. Stored in a 4-stage shift register advanced by `cen`. Each slot reads the oldest entry and pushes the updated one. Reset clears all entries to 0/0.
- **Step table:** 49 entries, standard OKI values: 16,17,19,21,23,25,28,31,34,37,41,45,50,55,60,66,73,80,88,97,107,118,130,143,157,173,190,209,230,253,279,307,337,371,408,449,494,544,598,658,724,796,876,963,1060,1166,1282,1411,1552.
- **Decode**, with `step = table[index]`:
  - `diff = step>>3 + (d2?step:0) + (d1?step>>1:0) + (d0?step>>2:0)`.
  - `signal' = signal ± diff`, subtracting when d3=1. The result saturates to -2048..2047.
  - Index adjust by magnitude: 0..3 → -1; 4 → +2; 5 → +4; 6 → +6; 7 → +8. The result is clamped to 0..48.
- **Inactive slot:** when `pipe_en`=0, the pushed state is 0/0 and the slot's contribution is 0. A channel restarting after idle therefore always decodes from 0/0.
- **Gain:** attenuation codes 0..8 map to gains 32,22,16,11,8,6,4,3,2 (≈3 dB steps). Codes 9..15 give gain 0.
  - `term = (signal' * gain) >>> 5`, an arithmetic shift that floors toward minus infinity. `term` is 12-bit signed.
- **Mixing:** the 14-bit signed accumulator sums the four terms of a frame. The range -8192..8188 cannot overflow, so no saturation is needed. After the slot-3 term is added, `sound` loads the total and the accumulator clears.

## Timing
- Every register changes only on `clk` edges with `cen`=1, except `sample`, which is a plain `clk` register.
- Pipeline, for inputs sampled at `cen` edge n:
  - edge n: decoded `signal'`/`index'` and the slot tag are registered.
  - edge n+1: `term` is registered.
  - edge n+2: the term is added to the accumulator.
- If the slot-3 input is sampled at edge n, `sound` updates at `cen` edge n+2. `sample` is high during the single `clk` cycle following that edge.
- The accumulator and `sound` follow the delayed slot tag, not the live counter, so frames stay aligned through the pipeline.
- While `cen` is held low, the whole block holds its state. `sample` is not asserted again.
- `rst` asserted mid-frame clears the slot counter, channel state, pipeline, accumulator, `sound` and `sample` immediately. Partial frames are discarded.
- There is no back-pressure. The upstream sequencer owns the rotation and must emit exactly one slot per `cen`.

## Configuration
- **`JT6295_ATT_EN` defined:** the gain table and multiplier are built, and `pipe_att` is applied as described above.
- **`JT6295_ATT_EN` undefined:**
  - `pipe_att` is ignored and `term = signal'`, so gain is fixed at 32.
  - No multiplier is instantiated.
  - Pipeline latency is unchanged; the gain stage becomes a plain register.

## Test plan
- **Reset:** after reset, `sound`=0 and `sample`=0. Run 8 `cen` slots with `pipe_en`=0 → `sound` stays 0, and `sample` pulses once per 4 `cen`.
- **Single-channel decode:** on slot 0 only, `pipe_en`=1, `att`=0, `data`=0111 in two consecutive frames, other slots idle. Expected:
  - channel 0 state goes 30/idx 8, then 93/idx 16.
  - `sound` = 30, then 93, each 2 `cen` after its frame's slot 3.
- **Negative and clamp:** `data`=1000 at state 0/0 → `signal`=-2, index stays 0. With `att`=2, `term`=-1 and `sound`=-1.
- **Saturation:** repeated `data`=0111 on one channel for 60 frames → `signal` saturates at 2047 and index at 48, with no wrap. Repeat with `data`=1111 → saturates at -2048.
- **Mixing and mute:**
  - all four channels at `data`=0111, `att` 0,1,2,9 → `sound` = 30+20+15+0 = 65.
  - drop `pipe_en` on channel 1 for one frame, then re-enable → its next decode restarts from 0/0.
- **Disruption:** assert `rst` mid-frame (after slot 1) → `sound` clears and the next frame starts at slot 0. Hold `cen` low for 20 cycles mid-frame → no output change and no `sample` pulses. Rerun the mixing case without `JT6295_ATT_EN` → `sound`=120.

Source files
------------

// File: rtl/jt6295_adpcm_mix.sv
// OKI ADPCM decoder and 4-channel mixer for the JT6295 serialized nibble stream.
// Optional build macro: JT6295_ATT_EN enables the per-channel attenuation multiplier.
module jt6295_adpcm_mix (
   input  logic               rst,
   input  logic               clk,
   input  logic               cen,
   input  logic               pipe_en,
   input  logic [3:0]         pipe_att,
   input  logic [3:0]         pipe_data,
   output logic signed [13:0] sound,
   output logic               sample
);

   function automatic logic [10:0] step_lut(input logic [5:0] idx);
      logic [10:0] s;
      case (idx)
         6'd0:  s = 11'd16;   6'd1:  s = 11'd17;   6'd2:  s = 11'd19;   6'd3:  s = 11'd21;
         6'd4:  s = 11'd23;   6'd5:  s = 11'd25;   6'd6:  s = 11'd28;   6'd7:  s = 11'd31;
         6'd8:  s = 11'd34;   6'd9:  s = 11'd37;   6'd10: s = 11'd41;   6'd11: s = 11'd45;
         6'd12: s = 11'd50;   6'd13: s = 11'd55;   6'd14: s = 11'd60;   6'd15: s = 11'd66;
         6'd16: s = 11'd73;   6'd17: s = 11'd80;   6'd18: s = 11'd88;   6'd19: s = 11'd97;
         6'd20: s = 11'd107;  6'd21: s = 11'd118;  6'd22: s = 11'd130;  6'd23: s = 11'd143;
         6'd24: s = 11'd157;  6'd25: s = 11'd173;  6'd26: s = 11'd190;  6'd27: s = 11'd209;
         6'd28: s = 11'd230;  6'd29: s = 11'd253;  6'd30: s = 11'd279;  6'd31: s = 11'd307;
         6'd32: s = 11'd337;  6'd33: s = 11'd371;  6'd34: s = 11'd408;  6'd35: s = 11'd449;
         6'd36: s = 11'd494;  6'd37: s = 11'd544;  6'd38: s = 11'd598;  6'd39: s = 11'd658;
         6'd40: s = 11'd724;  6'd41: s = 11'd796;  6'd42: s = 11'd876;  6'd43: s = 11'd963;
         6'd44: s = 11'd1060; 6'd45: s = 11'd1166; 6'd46: s = 11'd1282; 6'd47: s = 11'd1411;
         default: s = 11'd1552;
      endcase
      return s;
   endfunction

   logic [1:0]         slot_q, slot_d;
   logic signed [11:0] sig_q [4];
   logic [5:0]         idx_q [4];
   logic [1:0]         tag1_q, tag2_q;
   logic signed [11:0] term_q, term_d;
   logic signed [13:0] acc_q, acc_d, sound_q, sound_d, acc_sum;
   logic               sample_q, sample_d;

   // Decode the oldest channel entry; it is exactly one frame old.
   logic signed [11:0] cur_sig, sig_d;
   logic [5:0]         cur_idx, idx_d;
   logic [10:0]        step;
   logic [11:0]        diff;
   logic signed [13:0] sig_ext, diff_ext, sig_sum;
   logic signed [7:0]  idx_adj, idx_sum;

   always_comb begin
      cur_sig  = sig_q[3];
      cur_idx  = idx_q[3];
      step     = step_lut(cur_idx);
      diff     = {4'b0, step[10:3]}
               + (pipe_data[2] ? {1'b0, step}        : 12'd0)
               + (pipe_data[1] ? {2'b0, step[10:1]}  : 12'd0)
               + (pipe_data[0] ? {3'b0, step[10:2]}  : 12'd0);
      sig_ext  = {{2{cur_sig[11]}}, cur_sig};
      diff_ext = {2'b00, diff};
      sig_sum  = pipe_data[3] ? (sig_ext - diff_ext) : (sig_ext + diff_ext);
      case (pipe_data[2:0])
         3'd4:    idx_adj = 8'sd2;
         3'd5:    idx_adj = 8'sd4;
         3'd6:    idx_adj = 8'sd6;
         3'd7:    idx_adj = 8'sd8;
         default: idx_adj = -8'sd1;
      endcase
      idx_sum  = $signed({2'b00, cur_idx}) + idx_adj;
      sig_d    = 12'sd0;
      idx_d    = 6'd0;
      if (pipe_en) begin
         if (sig_sum > 14'sd2047)
            sig_d = 12'sd2047;
         else if (sig_sum < -14'sd2048)
            sig_d = -12'sd2048;
         else
            sig_d = sig_sum[11:0];
         if (idx_sum < 8'sd0)
            idx_d = 6'd0;
         else if (idx_sum > 8'sd48)
            idx_d = 6'd48;
         else
            idx_d = idx_sum[5:0];
      end
   end

`ifdef JT6295_ATT_EN
   function automatic logic [5:0] gain_lut(input logic [3:0] att);
      logic [5:0] g;
      case (att)
         4'd0: g = 6'd32; 4'd1: g = 6'd22; 4'd2: g = 6'd16;
         4'd3: g = 6'd11; 4'd4: g = 6'd8;  4'd5: g = 6'd6;
         4'd6: g = 6'd4;  4'd7: g = 6'd3;  4'd8: g = 6'd2;
         default: g = 6'd0;
      endcase
      return g;
   endfunction

   logic [3:0]         att1_q;
   logic signed [18:0] sig_x, gain_x, prod;
   logic               unused_prod;

   // Bits 16:5 of the product are the floor-shifted term; it always fits 12 bits.
   always_comb begin
      sig_x  = 19'(sig_q[0]);
      gain_x = {13'b0, gain_lut(att1_q)};
      prod   = sig_x * gain_x;
      term_d = prod[16:5];
   end
   assign unused_prod = ^{prod[18:17], prod[4:0]};

   always_ff @(posedge clk, posedge rst) begin
      if (rst)
         att1_q <= 4'd0;
      else if (cen)
         att1_q <= pipe_att;
   end
`else
   logic unused_att;
   assign unused_att = ^pipe_att;
   assign term_d     = sig_q[0];
`endif

   always_comb begin
      slot_d   = slot_q + 2'd1;
      acc_sum  = acc_q + {{2{term_q[11]}}, term_q};
      acc_d    = acc_sum;
      sound_d  = sound_q;
      sample_d = 1'b0;
      if (tag2_q == 2'd3) begin
         acc_d    = 14'sd0;
         sound_d  = acc_sum;
         sample_d = cen;
      end
   end

   always_ff @(posedge clk, posedge rst) begin
      if (rst) begin
         slot_q  <= 2'd0;
         tag1_q  <= 2'd0;
         tag2_q  <= 2'd0;
         term_q  <= 12'sd0;
         acc_q   <= 14'sd0;
         sound_q <= 14'sd0;
         for (int i = 0; i < 4; i++) begin
            sig_q[i] <= 12'sd0;
            idx_q[i] <= 6'd0;
         end
      end else if (cen) begin
         slot_q   <= slot_d;
         tag1_q   <= slot_q;
         tag2_q   <= tag1_q;
         term_q   <= term_d;
         acc_q    <= acc_d;
         sound_q  <= sound_d;
         sig_q[0] <= sig_d;
         idx_q[0] <= idx_d;
         for (int i = 1; i < 4; i++) begin
            sig_q[i] <= sig_q[i-1];
            idx_q[i] <= idx_q[i-1];
         end
      end
   end

   // The strobe is a plain clk register so it lasts exactly one clk cycle.
   always_ff @(posedge clk, posedge rst) begin
      if (rst)
         sample_q <= 1'b0;
      else
         sample_q <= sample_d;
   end

   assign sound  = sound_q;
   assign sample = sample_q;

endmodule

// File: tb/tb_jt6295_adpcm_mix.sv
// Scoreboard bench for jt6295_adpcm_mix: a per-channel ADPCM model predicts each frame sum and its cen edge.
module tb_jt6295_adpcm_mix;

   logic               rst, clk, cen, pipe_en;
   logic [3:0]         pipe_att, pipe_data;
   logic signed [13:0] sound;
   logic               sample;

   jt6295_adpcm_mix dut (
      .rst       (rst),
      .clk       (clk),
      .cen       (cen),
      .pipe_en   (pipe_en),
      .pipe_att  (pipe_att),
      .pipe_data (pipe_data),
      .sound     (sound),
      .sample    (sample)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int step_tab [49] = '{16,17,19,21,23,25,28,31,34,37,41,45,50,55,60,66,73,80,88,97,
                         107,118,130,143,157,173,190,209,230,253,279,307,337,371,408,
                         449,494,544,598,658,724,796,876,963,1060,1166,1282,1411,1552};
   int gain_tab [16] = '{32,22,16,11,8,6,4,3,2,0,0,0,0,0,0,0};

   logic [13:0] exp_q [$];
   int          exp_edge_q [$];
   int          m_sig [4];
   int          m_idx [4];
   int          m_slot, m_frame, cen_cnt;
   int          checks, errors;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic int floor_div32(input int p);
      if (p >= 0) return p / 32;
      return -((-p + 31) / 32);
   endfunction

   // Reference: each cen is one slot of channel == slot position in the frame.
   task automatic model_step(input bit en, input int att, input int d);
      int ch, s, ix, stp, diff, g, t, mag;
      ch = m_slot;
      s  = 0;
      ix = 0;
      if (en) begin
         stp  = step_tab[m_idx[ch]];
         diff = stp / 8;
         if ((d & 4) != 0) diff += stp;
         if ((d & 2) != 0) diff += stp / 2;
         if ((d & 1) != 0) diff += stp / 4;
         s = ((d & 8) != 0) ? m_sig[ch] - diff : m_sig[ch] + diff;
         if (s > 2047) s = 2047;
         if (s < -2048) s = -2048;
         mag = d & 7;
         ix = m_idx[ch] + ((mag < 4) ? -1 : (mag - 3) * 2);
         if (ix < 0) ix = 0;
         if (ix > 48) ix = 48;
      end
      m_sig[ch] = s;
      m_idx[ch] = ix;
`ifdef JT6295_ATT_EN
      g = gain_tab[att];
`else
      g = 32 + 0 * att;
`endif
      t = floor_div32(s * g);
      m_frame += t;
      if (ch == 3) begin
         exp_q.push_back(14'(m_frame));
         exp_edge_q.push_back(cen_cnt + 2);
         m_frame = 0;
      end
      cen_cnt++;
      m_slot = (m_slot + 1) % 4;
   endtask

   task automatic slot(input bit en, input logic [3:0] att, input logic [3:0] d);
      @(negedge clk);
      cen       = 1'b1;
      pipe_en   = en;
      pipe_att  = att;
      pipe_data = d;
      @(posedge clk);
      model_step(en, int'(att), int'(d));
   endtask

   // Inputs wander while cen is low; the block must ignore them.
   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         cen       = 1'b0;
         pipe_en   = 1'($urandom);
         pipe_att  = 4'($urandom);
         pipe_data = 4'($urandom);
      end
   endtask

   task automatic check_sound(input string name, input int exp);
      @(negedge clk);
      cen = 1'b0;
      check(name, int'(sound), exp);
   endtask

   task automatic do_reset();
      @(negedge clk);
      cen = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("reset_sound", int'(sound), 0);
      check("reset_sample", int'(sample), 0);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         m_sig[i] = 0;
         m_idx[i] = 0;
      end
      m_slot  = 0;
      m_frame = 0;
      exp_q.delete();
      exp_edge_q.delete();
   endtask

   // Monitor: every sample strobe must match the next predicted frame.
   always @(negedge clk) begin
      if (!rst && sample) begin
         if (exp_q.size() == 0) begin
            check("unexpected_sample", 1, 0);
         end else begin
            check("frame_sound", int'(sound), int'($signed(exp_q.pop_front())));
            check("frame_edge", cen_cnt - 1, exp_edge_q.pop_front());
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; cen = 1'b0; pipe_en = 1'b0; pipe_att = 4'd0; pipe_data = 4'd0;
      checks = 0; errors = 0; m_slot = 0; m_frame = 0; cen_cnt = 0;
      for (int i = 0; i < 4; i++) begin
         m_sig[i] = 0;
         m_idx[i] = 0;
      end
      do_reset();

      // Idle slots after reset
      repeat (8) slot(1'b0, 4'd0, 4'd0);

      // Single channel: 0/0 -> 30/8 -> 93/16
      do_reset();
      slot(1'b1, 4'd0, 4'd7); repeat (3) slot(1'b0, 4'd0, 4'd0);
      slot(1'b1, 4'd0, 4'd7); slot(1'b0, 4'd0, 4'd0);
      check_sound("single_first", 30);
      repeat (2) slot(1'b0, 4'd0, 4'd0);
      repeat (2) slot(1'b0, 4'd0, 4'd0);
      check_sound("single_second", 93);

      // Negative step with index clamp at 0
      do_reset();
      slot(1'b1, 4'd2, 4'd8); repeat (3) slot(1'b0, 4'd0, 4'd0);
      repeat (2) slot(1'b0, 4'd0, 4'd0);
`ifdef JT6295_ATT_EN
      check_sound("negative_att2", -1);
`else
      check_sound("negative_att2", -2);
`endif

      // Positive then negative saturation
      do_reset();
      repeat (60) begin slot(1'b1, 4'd0, 4'd7); repeat (3) slot(1'b0, 4'd0, 4'd0); end
      repeat (2) slot(1'b0, 4'd0, 4'd0);
      check_sound("sat_pos", 2047);
      do_reset();
      repeat (60) begin slot(1'b1, 4'd0, 4'd15); repeat (3) slot(1'b0, 4'd0, 4'd0); end
      repeat (2) slot(1'b0, 4'd0, 4'd0);
      check_sound("sat_neg", -2048);

      // Mixing, mute of channel 1, restart from 0/0
      do_reset();
      slot(1'b1, 4'd0, 4'd7); slot(1'b1, 4'd1, 4'd7); slot(1'b1, 4'd2, 4'd7); slot(1'b1, 4'd9, 4'd7);
      slot(1'b1, 4'd0, 4'd7); slot(1'b0, 4'd1, 4'd7);
`ifdef JT6295_ATT_EN
      check_sound("mix_four", 65);
`else
      check_sound("mix_four", 120);
`endif
      slot(1'b1, 4'd2, 4'd7); slot(1'b1, 4'd9, 4'd7);
      slot(1'b1, 4'd0, 4'd7); slot(1'b1, 4'd1, 4'd7); slot(1'b1, 4'd2, 4'd7); slot(1'b1, 4'd9, 4'd7);

      // Hold cen low mid-frame and inside the output latency window
      slot(1'b1, 4'd0, 4'd3); slot(1'b1, 4'd1, 4'd12);
      idle(20);
      slot(1'b1, 4'd0, 4'd5); slot(1'b1, 4'd3, 4'd6);
      idle(20);
      slot(1'b1, 4'd0, 4'd7); slot(1'b1, 4'd0, 4'd7);

      // Reset after slot 1 of a frame discards it
      do_reset();
      slot(1'b1, 4'd0, 4'd7); slot(1'b1, 4'd0, 4'd7); slot(1'b1, 4'd0, 4'd7); slot(1'b1, 4'd0, 4'd7);

      // Randomized traffic with random cen gaps
      for (int f = 0; f < 120; f++) begin
         for (int s = 0; s < 4; s++) begin
            slot(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
         end
      end

      // Drain the final frame, then nothing may remain outstanding
      repeat (2) slot(1'b0, 4'd0, 4'd0);
      idle(4);
      check("drain_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
